// File: rtl/result_fifo_if.sv
// Write-side, drain-side and status signals of the result FIFO.
interface result_fifo_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 3
) ();
    logic              wr_req;
    logic [WIDTH-1:0]  wr_data;
    logic              full;
    logic              almost_full;
    logic              overflow;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [ADDR_W:0]   level;

    // Producer/consumer side: drives strobes, sees status and head word.
    modport master (
        output wr_req, wr_data, out_ready,
        input  full, almost_full, overflow, out_valid, out_data, level
    );

    // FIFO side.
    modport slave (
        input  wr_req, wr_data, out_ready,
        output full, almost_full, overflow, out_valid, out_data, level
    );
endinterface

// File: rtl/result_fifo.sv
// Result FIFO: captures wrapper write pulses, drains first-word-fall-through
// through a valid/ready port; occupancy count, flush and sticky overflow.
module result_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    result_fifo_if.slave  bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic              w_full;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_mem_we;
    logic [CNT_W-1:0]  w_count_nxt;

    // Status flags derive from the registered count only.
    assign w_full   = (r_count == CNT_FULL);
    assign w_valid  = (r_count != '0);
    assign w_push   = bus.wr_req && !w_full;
    assign w_pop    = w_valid && bus.out_ready;
    assign w_mem_we = w_push && !rst && !clr;

    assign bus.full        = w_full;
    assign bus.almost_full = (r_count >= CNT_AF);
    assign bus.overflow    = r_overflow;
    assign bus.out_valid   = w_valid;
    assign bus.out_data    = r_mem[r_rd_ptr];
    assign bus.level       = r_count;

    // Next occupancy: push and pop together leave the count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, count and sticky overflow; rst dominates clr, clr dominates traffic.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (bus.wr_req && w_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end
endmodule

// File: tb/tb_result_fifo.sv
// Scoreboard bench for result_fifo: expected words queued on accepted push,
// compared against the head word every cycle the FIFO presents one.
module tb_result_fifo;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned AF_LEVEL = 6;

    logic clk;
    logic rst;
    logic clr;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] sb_q[$];
    logic             m_ovf;

    result_fifo_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    result_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check DUT status against the model, then advance the model.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                        input logic c, input logic rs);
        int cnt;
        logic pop;
        logic push;
        bus.wr_req    = w;
        bus.wr_data   = d;
        bus.out_ready = r;
        clr           = c;
        rst           = rs;
        #1;
        cnt = sb_q.size();
        check("level",       32'(bus.level),       32'(cnt));
        check("out_valid",   32'(bus.out_valid),   32'(cnt != 0));
        check("full",        32'(bus.full),        32'(cnt == DEPTH));
        check("almost_full", 32'(bus.almost_full), 32'(cnt >= AF_LEVEL));
        check("overflow",    32'(bus.overflow),    32'(m_ovf));
        if (cnt != 0) begin
            check("out_data", 32'(bus.out_data), 32'(sb_q[0]));
        end
        if (rs || c) begin
            sb_q.delete();
            m_ovf = 1'b0;
        end else begin
            pop  = (cnt != 0) && r;
            push = w && (cnt != DEPTH);
            if (w && cnt == DEPTH) m_ovf = 1'b1;
            if (pop)  void'(sb_q.pop_front());
            if (push) sb_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_ovf         = 1'b0;
        rst           = 1'b1;
        clr           = 1'b0;
        bus.wr_req    = 1'b1;
        bus.wr_data   = 8'hE1;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.wr_req = 1'b0;
        #1;
        check("rst_level",    32'(bus.level),     32'd0);
        check("rst_valid",    32'(bus.out_valid), 32'd0);
        check("rst_overflow", 32'(bus.overflow),  32'd0);
        check("rst_full",     32'(bus.full),      32'd0);

        // Fill back-to-back, then overflow attempts, including one with a pop.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAB, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Refill to full, flush with traffic in the same cycle.
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Advance pointers, then simultaneous push/pop across the wrap.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Empty fall-through with consumer ready.
        step(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Long stall, then reset alongside a write.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("final_valid", 32'(bus.out_valid), 32'd0);
        check("final_level", 32'(bus.level),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
